// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate BIST engine: opcodes, FSM encoding,
// vector ordering and the 2-input gate truth-table function.
package gate_bist_pkg;

    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_XOR  = 2;
    localparam int OP_NAND = 3;
    localparam int OP_NOR  = 4;
    localparam int OP_XNOR = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Vectors are applied as {a,b} = 00, 01, 10, 11.
    localparam logic [1:0] VEC_FIRST = 2'b00;
    localparam logic [1:0] VEC_LAST  = 2'b11;

    function automatic logic gate_op_eval(input int op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of one library 2-input gate, selected by GATE_OP.
// Reusable by any checker that needs the expected gate output.
module gate_ref_model
    import gate_bist_pkg::*;
#(
    parameter int GATE_OP = OP_OR
) (
    input  logic a,
    input  logic b,
    output logic expected
);

    if (GATE_OP < OP_AND || GATE_OP > OP_XNOR) begin : g_bad_op
        $error("gate_ref_model: unsupported GATE_OP %0d", GATE_OP);
    end

    assign expected = gate_op_eval(GATE_OP, a, b);

endmodule

// File: rtl/gate_bist.sv
// Sequential self-test engine for a 2-input gate: steps {a,b} through all
// four vectors, samples f after a settle window and records mismatches.
//
//   state  | meaning
//   IDLE   | a=b=0, waiting for start
//   SETTLE | {a,b}=vec driven, counting SETTLE_CYCLES
//   SAMPLE | compare f against the reference, advance or finish
//   DONE   | one-cycle done pulse, pass valid
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int GATE_OP       = OP_OR,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       f,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("gate_bist: SETTLE_CYCLES %0d out of range 1..255", SETTLE_CYCLES);
    end

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] fail_q, fail_d;
    logic       pass_q, pass_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       expected;

    gate_ref_model #(
        .GATE_OP (GATE_OP)
    ) u_ref (
        .a        (vec_q[1]),
        .b        (vec_q[0]),
        .expected (expected)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= VEC_FIRST;
            cnt_q   <= 8'd0;
            fail_q  <= 4'd0;
            pass_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d   = VEC_FIRST;
                    cnt_d   = 8'd0;
                    fail_d  = 4'd0;
                    pass_d  = 1'b0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_SAMPLE;
                    end
                end
            end
            ST_SAMPLE: begin
                // An abort here discards the current vector's comparison.
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (f != expected) begin
                        fail_d[vec_q] = 1'b1;
                    end
                    if (vec_q == VEC_LAST) begin
                        pass_d  = (fail_d == 4'd0);
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + 2'd1;
                        cnt_d   = 8'd0;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        a_d    = busy_d & vec_d[1];
        b_d    = busy_d & vec_d[0];
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench: three engines (OR vs OR gate, AND vs OR gate, XOR vs f=1)
// share start/abort/rst and are checked against hand-computed results.
module tb_gate_bist;

    logic clk, rst, start, abort;
    logic a_or, b_or, busy_or, done_or, pass_or;
    logic a_and, b_and, busy_and, done_and, pass_and;
    logic a_xor, b_xor, busy_xor, done_xor, pass_xor;
    logic [3:0] fm_or, fm_and, fm_xor;
    logic f_or, f_and, f_xor;

    int tests = 0;
    int fails = 0;

    assign f_or  = a_or | b_or;
    assign f_and = a_and | b_and;
    assign f_xor = 1'b1;

    gate_bist #(.GATE_OP(1), .SETTLE_CYCLES(2)) u_or (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .f(f_or),
        .a(a_or), .b(b_or), .busy(busy_or), .done(done_or), .pass(pass_or),
        .fail_mask(fm_or)
    );

    gate_bist #(.GATE_OP(0), .SETTLE_CYCLES(2)) u_and (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .f(f_and),
        .a(a_and), .b(b_and), .busy(busy_and), .done(done_and), .pass(pass_and),
        .fail_mask(fm_and)
    );

    gate_bist #(.GATE_OP(2), .SETTLE_CYCLES(2)) u_xor (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .f(f_xor),
        .a(a_xor), .b(b_xor), .busy(busy_xor), .done(done_xor), .pass(pass_xor),
        .fail_mask(fm_xor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        #3;
        tests++;
        if ({a_or, b_or, busy_or, done_or, pass_or, fm_or} !== 9'b0) begin
            fails++;
            $display("FAIL reset_state: got %b want 000000000",
                     {a_or, b_or, busy_or, done_or, pass_or, fm_or});
        end
        cycle(); cycle();
        rst = 1'b0;
        cycle(); cycle();
        tests++;
        if (busy_or !== 1'b0 || done_or !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy_or, done_or);
        end
    endtask

    // Full run on all three engines; vectors hold 3 cycles each, done at cycle 13.
    task automatic test_full_run();
        logic [1:0] ev;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            ev = 2'((c - 1) / 3);
            tests++;
            if ({a_or, b_or} !== ev || busy_or !== 1'b1 || done_or !== 1'b0) begin
                fails++;
                $display("FAIL run_vector c%0d: ab=%b busy=%b done=%b want ab=%b busy=1 done=0",
                         c, {a_or, b_or}, busy_or, done_or, ev);
            end
            cycle();
        end
        tests++;
        if (done_or !== 1'b1 || busy_or !== 1'b0 || {a_or, b_or} !== 2'b00) begin
            fails++;
            $display("FAIL done_cycle13: done=%b busy=%b ab=%b want 1 0 00",
                     done_or, busy_or, {a_or, b_or});
        end
        tests++;
        if (pass_or !== 1'b1 || fm_or !== 4'b0000) begin
            fails++;
            $display("FAIL or_result: pass=%b mask=%b want 1 0000", pass_or, fm_or);
        end
        tests++;
        if (pass_and !== 1'b0 || fm_and !== 4'b0110) begin
            fails++;
            $display("FAIL and_vs_or_result: pass=%b mask=%b want 0 0110", pass_and, fm_and);
        end
        tests++;
        if (pass_xor !== 1'b0 || fm_xor !== 4'b1001) begin
            fails++;
            $display("FAIL xor_vs_one_result: pass=%b mask=%b want 0 1001", pass_xor, fm_xor);
        end
        cycle();
        tests++;
        if (done_or !== 1'b0 || pass_or !== 1'b1) begin
            fails++;
            $display("FAIL done_one_cycle: done=%b pass=%b want 0 1", done_or, pass_or);
        end
    endtask

    task automatic test_restart_clears();
        start = 1'b1;
        cycle();
        start = 1'b0;
        tests++;
        if (fm_xor !== 4'b0000 || pass_xor !== 1'b0 || busy_xor !== 1'b1) begin
            fails++;
            $display("FAIL restart_clear: mask=%b pass=%b busy=%b want 0000 0 1",
                     fm_xor, pass_xor, busy_xor);
        end
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        tests++;
        if (busy_xor !== 1'b0 || done_xor !== 1'b0) begin
            fails++;
            $display("FAIL abort_settle: busy=%b done=%b want 0 0", busy_xor, done_xor);
        end
        cycle();
    endtask

    // Abort in SAMPLE of vector 2 (cycle 9): vector 2's comparison is dropped.
    task automatic test_abort_sample();
        int ndone = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (8) cycle();
        tests++;
        if ({a_and, b_and} !== 2'b10 || busy_and !== 1'b1) begin
            fails++;
            $display("FAIL pre_abort_vec2: ab=%b busy=%b want 10 1", {a_and, b_and}, busy_and);
        end
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        tests++;
        if (busy_and !== 1'b0 || {a_and, b_and} !== 2'b00 || pass_and !== 1'b0 || done_and !== 1'b0) begin
            fails++;
            $display("FAIL abort_outputs: busy=%b ab=%b pass=%b done=%b want 0 00 0 0",
                     busy_and, {a_and, b_and}, pass_and, done_and);
        end
        tests++;
        if (fm_and !== 4'b0010 || fm_or !== 4'b0000 || fm_xor !== 4'b0001) begin
            fails++;
            $display("FAIL abort_partial_mask: and=%b or=%b xor=%b want 0010 0000 0001",
                     fm_and, fm_or, fm_xor);
        end
        for (int i = 0; i < 20; i++) begin
            if (done_and === 1'b1) ndone++;
            cycle();
        end
        tests++;
        if (ndone != 0 || busy_and !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_done: pulses=%0d busy=%b want 0 0", ndone, busy_and);
        end
    endtask

    task automatic test_abort_idle();
        abort = 1'b1;
        cycle();
        tests++;
        if (busy_or !== 1'b0 || done_or !== 1'b0 || fm_and !== 4'b0010) begin
            fails++;
            $display("FAIL abort_in_idle: busy=%b done=%b mask=%b want 0 0 0010",
                     busy_or, done_or, fm_and);
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        tests++;
        if (busy_or !== 1'b1 || fm_and !== 4'b0000) begin
            fails++;
            $display("FAIL start_beats_abort: busy=%b mask=%b want 1 0000", busy_or, fm_and);
        end
        repeat (12) cycle();
        tests++;
        if (done_or !== 1'b1 || pass_or !== 1'b1) begin
            fails++;
            $display("FAIL start_beats_abort_done: done=%b pass=%b want 1 1", done_or, pass_or);
        end
        cycle();
    endtask

    // start held high through the run and the DONE cycle: one done pulse only.
    task automatic test_back_to_back();
        int ndone = 0;
        int done_at = -1;
        start = 1'b1;
        cycle();
        for (int c = 1; c <= 14; c++) begin
            if (done_or === 1'b1) begin
                ndone++;
                done_at = c;
            end
            if (c == 14) start = 1'b0;
            cycle();
        end
        for (int i = 0; i < 20; i++) begin
            if (done_or === 1'b1) ndone++;
            cycle();
        end
        tests++;
        if (ndone != 1 || done_at != 13) begin
            fails++;
            $display("FAIL start_spam_done: pulses=%0d at cycle %0d want 1 at 13", ndone, done_at);
        end
        tests++;
        if (busy_or !== 1'b0) begin
            fails++;
            $display("FAIL start_spam_no_queue: busy=%b want 0", busy_or);
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (4) cycle();
        tests++;
        if ({a_or, b_or} !== 2'b01 || fm_xor !== 4'b0001 || busy_xor !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_state: ab=%b mask=%b busy=%b want 01 0001 1",
                     {a_or, b_or}, fm_xor, busy_xor);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({a_or, b_or, busy_or} !== 3'b000 || fm_xor !== 4'b0000 || busy_xor !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: ab=%b busy=%b mask=%b want 00 0 0000",
                     {a_or, b_or}, busy_or, fm_xor);
        end
        cycle();
        rst = 1'b0;
        repeat (15) cycle();
        tests++;
        if (busy_or !== 1'b0 || done_or !== 1'b0 || {a_or, b_or} !== 2'b00) begin
            fails++;
            $display("FAIL post_reset_idle: busy=%b done=%b ab=%b want 0 0 00",
                     busy_or, done_or, {a_or, b_or});
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_restart_clears();
        test_abort_sample();
        test_abort_idle();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
